// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher
// Description : Turns single-cycle event strobes into clean pulses of a
//               minimum width, each followed by a guaranteed low gap.
//               Strobes that arrive while a pulse is in flight are counted
//               in a saturating queue. They are then replayed back-to-back,
//               so every strobe becomes one distinct rising edge at a slow
//               consumer.
//
// Parameters  : HIGH_CYCLES   - cycles out is held high per pulse (>= 1)
//               LOW_CYCLES    - minimum cycles out is held low after a
//                               pulse (>= 1)
//               PENDING_WIDTH - width of the queued-strobe counter
//                               (max queued = 2**PENDING_WIDTH-1)
//
// Ports       : clock   in   1              system clock, rising edge
//               reset   in   1              asynchronous, active-high
//               in      in   1              event strobe, one event per
//                                           high cycle
//               out     out  1              stretched pulse (registered)
//               busy    out  1              high while a pulse or its gap
//                                           is in progress
//               pending out  PENDING_WIDTH  events queued, not yet started
//               dropped out  1              one-cycle flag, an event was
//                                           lost to saturation (registered)
//
// Options     : PULSE_RETRIGGER_EN - when defined, a strobe during the high
//               phase restarts the high-time count instead of queueing.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
   parameter int HIGH_CYCLES   = 4,
   parameter int LOW_CYCLES    = 4,
   parameter int PENDING_WIDTH = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in,
   output logic                     out,
   output logic                     busy,
   output logic [PENDING_WIDTH-1:0] pending,
   output logic                     dropped
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int C_MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

   // The counter is loaded with N-1 on entering a phase. The phase ends in
   // the cycle where the count reads zero, so each phase lasts exactly N
   // cycles.
   localparam logic [C_CNT_W-1:0]       C_HIGH_LOAD   = C_CNT_W'(HIGH_CYCLES - 1);
   localparam logic [C_CNT_W-1:0]       C_LOW_LOAD    = C_CNT_W'(LOW_CYCLES - 1);
   localparam logic [C_CNT_W-1:0]       C_CNT_ZERO    = '0;
   localparam logic [PENDING_WIDTH-1:0] C_PEND_MAX    = {PENDING_WIDTH{1'b1}};
   localparam logic [PENDING_WIDTH-1:0] C_PEND_ZERO   = '0;

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [C_CNT_W-1:0]         r_count;
   logic [C_CNT_W-1:0]         w_count_nxt;
   logic [PENDING_WIDTH-1:0]   r_pending;
   logic [PENDING_WIDTH-1:0]   w_pending_nxt;
   logic                       r_out;
   logic                       r_dropped;
   logic                       w_dropped_nxt;

   logic                       w_expired;
   logic                       w_low_end;
   logic                       w_deq;
   logic                       w_start_direct;
   logic                       w_enq;
   logic                       w_retrigger;

   // ------------------------------------------------------------------------
   // Retrigger option: a strobe seen in the high phase extends that pulse.
   // Without the option, such a strobe is queued like any other.
   // ------------------------------------------------------------------------
`ifdef PULSE_RETRIGGER_EN
   assign w_retrigger = in && (r_state == ST_HIGH);
`else
   assign w_retrigger = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Event classification
   // ------------------------------------------------------------------------
   always_comb begin
      w_expired      = (r_count == C_CNT_ZERO);
      w_low_end      = (r_state == ST_LOW) && w_expired;

      // At the end of the gap, a queued event takes priority. If the queue is
      // empty, a strobe arriving in that same cycle starts the next pulse
      // directly and never touches the queue.
      w_deq          = w_low_end && (r_pending != C_PEND_ZERO);
      w_start_direct = w_low_end && (r_pending == C_PEND_ZERO) && in;

      // Any other strobe while busy is queued, unless it retriggered.
      w_enq          = in && (r_state != ST_IDLE) && !w_start_direct && !w_retrigger;
   end

   // ------------------------------------------------------------------------
   // Next-state, phase counter and queue logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_pending_nxt = r_pending;
      w_dropped_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (in) begin
               w_state_nxt = ST_HIGH;
               w_count_nxt = C_HIGH_LOAD;
            end
         end

         ST_HIGH: begin
            if (w_retrigger) begin
               w_count_nxt = C_HIGH_LOAD;
            end else if (w_expired) begin
               w_state_nxt = ST_LOW;
               w_count_nxt = C_LOW_LOAD;
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end

         ST_LOW: begin
            if (w_expired) begin
               // Move straight into the next pulse, with no idle cycle, when
               // there is work to do.
               if (w_deq || w_start_direct) begin
                  w_state_nxt = ST_HIGH;
                  w_count_nxt = C_HIGH_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_count_nxt = C_CNT_ZERO;
               end
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = C_CNT_ZERO;
         end
      endcase

      // Queue update. An enqueue and a dequeue in the same cycle cancel out.
      // The saturation check therefore applies only when no dequeue frees a
      // slot.
      if (w_enq && w_deq) begin
         w_pending_nxt = r_pending;
      end else if (w_enq) begin
         if (r_pending == C_PEND_MAX) begin
            w_dropped_nxt = 1'b1;
         end else begin
            w_pending_nxt = r_pending + 1'b1;
         end
      end else if (w_deq) begin
         w_pending_nxt = r_pending - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_count   <= C_CNT_ZERO;
         r_pending <= C_PEND_ZERO;
         r_out     <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pending <= w_pending_nxt;
         // The output register tracks the next state, so out is glitch-free
         // and coincides exactly with the high phase.
         r_out     <= (w_state_nxt == ST_HIGH);
         r_dropped <= w_dropped_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out     = r_out;
   assign busy    = (r_state != ST_IDLE);
   assign pending = r_pending;
   assign dropped = r_dropped;

endmodule
`default_nettype wire
